// File: rtl/vip_pkg.sv
// Shared pixel width, 3x3 window tap layout and control state encoding for the
// gray-matrix video pipeline.
package vip_pkg;

  localparam int unsigned PIX_W    = 8;
  localparam int unsigned WIN_TAPS = 9;
  localparam int unsigned WIN_W    = PIX_W * WIN_TAPS;

  // Tap slot in the packed window: p11 occupies the top byte, p33 the bottom byte.
  localparam int unsigned TAP_P11 = 8;
  localparam int unsigned TAP_P12 = 7;
  localparam int unsigned TAP_P13 = 6;
  localparam int unsigned TAP_P21 = 5;
  localparam int unsigned TAP_P22 = 4;
  localparam int unsigned TAP_P23 = 3;
  localparam int unsigned TAP_P31 = 2;
  localparam int unsigned TAP_P32 = 1;
  localparam int unsigned TAP_P33 = 0;

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    ACTIVE     = 1'b1
  } vip_state_e;

endpackage

// File: rtl/vip_line_buffer.sv
// One video line of pixel storage: single clock, registered read (1 clk latency),
// read-before-write when both ports hit the same address.
module vip_line_buffer
  import vip_pkg::*;
#(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned AW    = 10
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem [DEPTH];

  // Storage carries no reset; stale words are masked downstream by position.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/vip_gray_matrix_3x3.sv
// Builds a 3x3 gray-pixel neighbourhood per accepted pixel using two line buffers;
// out-of-image taps are zeroed from the row/column position.
module vip_gray_matrix_3x3
  import vip_pkg::*;
#(
  parameter int unsigned IMG_HDISP = 640,
  parameter int unsigned IMG_VDISP = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  input  logic [PIX_W-1:0] per_img_Gray,
  output logic             matrix_frame_vsync,
  output logic             matrix_frame_href,
  output logic             matrix_frame_clken,
  output logic [WIN_W-1:0] matrix_window
);

  localparam int unsigned COL_W = $clog2(IMG_HDISP + 1);
  localparam int unsigned AW    = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int unsigned ROW_W = (IMG_VDISP > 1) ? $clog2(IMG_VDISP) : 1;
  localparam logic [COL_W-1:0] COL_END  = COL_W'(IMG_HDISP);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_VDISP - 1);

  vip_state_e       state_q;
  logic             vsync_q;
  logic             href_q;
  logic             line_hit_q;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;

  logic             vsync_rise_c;
  logic             href_fall_c;
  logic             accept_c;

  logic             s1_vld_q;
  logic [PIX_W-1:0] s1_pix_q;
  logic [COL_W-1:0] s1_col_q;
  logic [ROW_W-1:0] s1_row_q;
  logic             s2_vld_q;
  logic [COL_W-1:0] s2_col_q;
  logic [ROW_W-1:0] s2_row_q;

  logic [PIX_W-1:0] p11_q, p12_q, p13_q;
  logic [PIX_W-1:0] p21_q, p22_q, p23_q;
  logic [PIX_W-1:0] p31_q, p32_q, p33_q;

  logic [PIX_W-1:0] lb0_rd;
  logic [PIX_W-1:0] lb1_rd;

  logic [1:0]       vsync_pipe_q;
  logic [1:0]       href_pipe_q;

  logic [WIN_TAPS-1:0][PIX_W-1:0] win_c;
  logic             row1_ok_c, row2_ok_c, col1_ok_c, col2_ok_c;

  assign vsync_rise_c = per_frame_vsync & ~vsync_q;
  assign href_fall_c  = href_q & ~per_frame_href;
  assign accept_c     = (state_q == ACTIVE) & per_frame_vsync & per_frame_href &
                        per_frame_clken & (col_q != COL_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_FRAME;
    end else if (!per_frame_vsync) begin
      state_q <= WAIT_FRAME;
    end else if (vsync_rise_c) begin
      state_q <= ACTIVE;
    end
  end

  // vsync history resets high so a frame already in progress at reset release is skipped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q    <= 1'b1;
      href_q     <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      line_hit_q <= 1'b0;
    end else begin
      vsync_q <= per_frame_vsync;
      href_q  <= per_frame_href;
      if (!per_frame_vsync || (state_q != ACTIVE)) begin
        col_q      <= '0;
        row_q      <= '0;
        line_hit_q <= 1'b0;
      end else if (href_fall_c) begin
        col_q      <= '0;
        line_hit_q <= 1'b0;
        if (line_hit_q && (row_q != ROW_LAST)) begin
          row_q <= row_q + ROW_W'(1);
        end
      end else if (accept_c) begin
        col_q      <= col_q + COL_W'(1);
        line_hit_q <= 1'b1;
      end
    end
  end

  // line0 holds row r-1, line1 holds row r-2; line1 is refilled a cycle later with line0's old word.
  vip_line_buffer #(.DEPTH(IMG_HDISP), .AW(AW)) u_line0 (
    .clk     (clk),
    .wr_en   (accept_c),
    .wr_addr (AW'(col_q)),
    .wr_data (per_img_Gray),
    .rd_en   (accept_c),
    .rd_addr (AW'(col_q)),
    .rd_data (lb0_rd)
  );

  vip_line_buffer #(.DEPTH(IMG_HDISP), .AW(AW)) u_line1 (
    .clk     (clk),
    .wr_en   (s1_vld_q),
    .wr_addr (AW'(s1_col_q)),
    .wr_data (lb0_rd),
    .rd_en   (accept_c),
    .rd_addr (AW'(col_q)),
    .rd_data (lb1_rd)
  );

  // Stage 1 captures the pixel and its position; stage 2 shifts the window columns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_pix_q <= '0;
      s1_col_q <= '0;
      s1_row_q <= '0;
      s2_vld_q <= 1'b0;
      s2_col_q <= '0;
      s2_row_q <= '0;
      p11_q <= '0; p12_q <= '0; p13_q <= '0;
      p21_q <= '0; p22_q <= '0; p23_q <= '0;
      p31_q <= '0; p32_q <= '0; p33_q <= '0;
    end else begin
      s1_vld_q <= accept_c;
      s1_pix_q <= per_img_Gray;
      s1_col_q <= col_q;
      s1_row_q <= row_q;
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        s2_col_q <= s1_col_q;
        s2_row_q <= s1_row_q;
        p11_q <= p12_q; p12_q <= p13_q; p13_q <= lb1_rd;
        p21_q <= p22_q; p22_q <= p23_q; p23_q <= lb0_rd;
        p31_q <= p32_q; p32_q <= p33_q; p33_q <= s1_pix_q;
      end
    end
  end

  always_comb begin
    row1_ok_c = (s2_row_q != '0);
    row2_ok_c = (s2_row_q > ROW_W'(1));
    col1_ok_c = (s2_col_q != '0);
    col2_ok_c = (s2_col_q > COL_W'(1));
    win_c = '0;
    win_c[TAP_P11] = (row2_ok_c && col2_ok_c) ? p11_q : '0;
    win_c[TAP_P12] = (row2_ok_c && col1_ok_c) ? p12_q : '0;
    win_c[TAP_P13] = row2_ok_c ? p13_q : '0;
    win_c[TAP_P21] = (row1_ok_c && col2_ok_c) ? p21_q : '0;
    win_c[TAP_P22] = (row1_ok_c && col1_ok_c) ? p22_q : '0;
    win_c[TAP_P23] = row1_ok_c ? p23_q : '0;
    win_c[TAP_P31] = col2_ok_c ? p31_q : '0;
    win_c[TAP_P32] = col1_ok_c ? p32_q : '0;
    win_c[TAP_P33] = p33_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_pipe_q       <= '0;
      href_pipe_q        <= '0;
      matrix_frame_vsync <= 1'b0;
      matrix_frame_href  <= 1'b0;
      matrix_frame_clken <= 1'b0;
      matrix_window      <= '0;
    end else begin
      vsync_pipe_q       <= {vsync_pipe_q[0], per_frame_vsync};
      href_pipe_q        <= {href_pipe_q[0], per_frame_href};
      matrix_frame_vsync <= vsync_pipe_q[0];
      matrix_frame_href  <= href_pipe_q[0];
      matrix_frame_clken <= s2_vld_q;
      if (s2_vld_q) begin
        matrix_window <= win_c;
      end
    end
  end

endmodule

// File: tb/tb_vip_gray_matrix_3x3.sv
// Randomized bench for vip_gray_matrix_3x3 against an image-array reference model.
module tb_vip_gray_matrix_3x3;

  localparam int H = 10;
  localparam int V = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        per_frame_vsync = 1'b0;
  logic        per_frame_href = 1'b0;
  logic        per_frame_clken = 1'b0;
  logic [7:0]  per_img_Gray = 8'd0;
  logic        matrix_frame_vsync;
  logic        matrix_frame_href;
  logic        matrix_frame_clken;
  logic [71:0] matrix_window;

  always #5 clk = ~clk;

  vip_gray_matrix_3x3 #(.IMG_HDISP(H), .IMG_VDISP(V)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .per_frame_vsync    (per_frame_vsync),
    .per_frame_href     (per_frame_href),
    .per_frame_clken    (per_frame_clken),
    .per_img_Gray       (per_img_Gray),
    .matrix_frame_vsync (matrix_frame_vsync),
    .matrix_frame_href  (matrix_frame_href),
    .matrix_frame_clken (matrix_frame_clken),
    .matrix_window      (matrix_window)
  );

  typedef struct {
    logic [71:0] win;
    int          cyc;
    int          r;
    int          c;
    int          mode;
  } exp_t;

  exp_t exq[$];
  exp_t mon_e;
  int   img[0:15][0:11];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   win_cnt = 0;
  int   since_rst = 0;
  bit   model_on = 1'b0;
  logic vs_h1 = 1'b0, vs_h2 = 1'b0, hs_h1 = 1'b0, hs_h2 = 1'b0;

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Window at (line l, col c): taps outside the image (row clamped at V-1) read zero.
  function automatic logic [71:0] model_win(input int l, input int c);
    logic [71:0] w;
    int rm;
    w  = '0;
    rm = (l < V - 1) ? l : V - 1;
    for (int dr = 0; dr < 3; dr++) begin
      for (int dc = 0; dc < 3; dc++) begin
        if ((rm - (2 - dr) >= 0) && (c - (2 - dc) >= 0))
          w[(8 - (dr * 3 + dc)) * 8 +: 8] = 8'(img[l - (2 - dr)][c - (2 - dc)]);
      end
    end
    return w;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) since_rst = 0;
    else since_rst++;
    if (since_rst >= 3) begin
      check_eq("vsync_delay", 72'(matrix_frame_vsync), 72'(vs_h2));
      check_eq("href_delay", 72'(matrix_frame_href), 72'(hs_h2));
    end
    vs_h2 = vs_h1; vs_h1 = per_frame_vsync;
    hs_h2 = hs_h1; hs_h1 = per_frame_href;
    if (matrix_frame_clken) win_cnt++;
    if (exq.size() > 0 && exq[0].cyc == cyc) begin
      mon_e = exq.pop_front();
      check_eq($sformatf("clken_r%0d_c%0d", mon_e.r, mon_e.c), 72'(matrix_frame_clken), 72'd1);
      check_eq($sformatf("win_m%0d_r%0d_c%0d", mon_e.mode, mon_e.r, mon_e.c), matrix_window, mon_e.win);
      if (mon_e.mode == 0 && mon_e.r == 3 && mon_e.c == 4)
        check_eq("win_r3c4_const", matrix_window, 72'h0c0d0e_161718_202122);
      if (mon_e.mode == 0 && mon_e.r == 0 && mon_e.c == 0)
        check_eq("win_r0c0_const", matrix_window, 72'h0);
      if (mon_e.mode == 0 && mon_e.r == 1 && mon_e.c == 1)
        check_eq("win_r1c1_const", matrix_window, 72'h000000_000001_000a0b);
      if (mon_e.mode == 1 && mon_e.r == 1 && mon_e.c == 1)
        check_eq("win_inv_r1c1_const", matrix_window, 72'h000000_00fffe_00f5f4);
    end else if (matrix_frame_clken) begin
      check_eq("spurious_clken", 72'(matrix_frame_clken), 72'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    exq.delete();
    model_on = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_clken", 72'(matrix_frame_clken), 72'd0);
      check_eq("rst_window", matrix_window, 72'd0);
      check_eq("rst_vsync", 72'(matrix_frame_vsync), 72'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // mode: 0 r*10+c, 1 inverted, 2 random; cmode: 0 every clk, 1 one-of-three, 2 random.
  task automatic run_frame(input int mode, input int cmode, input int nlines,
                           input int long_line, input int rst_line, input int exp_cnt);
    int   phase;
    int   ns;
    int   s;
    logic stb;
    logic [7:0] px;
    exp_t e;
    phase = 0;
    model_on = 1'b1;
    win_cnt = 0;
    per_frame_vsync = 1'b1;
    repeat (3) tick();
    for (int l = 0; l < nlines; l++) begin
      ns = (l == long_line) ? H + 2 : H;
      s = 0;
      per_frame_href = 1'b1;
      while (s < ns) begin
        tick();
        if (l == rst_line && s == 5 && model_on) pulse_reset();
        case (cmode)
          0:       stb = 1'b1;
          1:       stb = (phase % 3 == 0);
          default: stb = 1'($urandom_range(0, 1));
        endcase
        phase++;
        if (mode == 0)      px = 8'(l * 10 + s);
        else if (mode == 1) px = 8'(255 - (l * 10 + s));
        else                px = 8'($urandom_range(0, 255));
        per_frame_clken = stb;
        per_img_Gray = px;
        if (stb) begin
          if (model_on && s < H) begin
            img[l][s] = int'(px);
            e.win = model_win(l, s);
            e.cyc = cyc + 3;
            e.r = l;
            e.c = s;
            e.mode = mode;
            exq.push_back(e);
          end
          s++;
        end
      end
      tick();
      per_frame_href = 1'b0;
      per_frame_clken = 1'b0;
      // Strobes while href is low must be ignored.
      repeat (3) begin
        tick();
        per_frame_clken = 1'($urandom_range(0, 1));
        per_img_Gray = 8'($urandom_range(0, 255));
      end
      tick();
      per_frame_clken = 1'b0;
    end
    per_frame_vsync = 1'b0;
    repeat (4) tick();
    if (exp_cnt >= 0) check_eq("frame_windows", 72'(win_cnt), 72'(exp_cnt));
    check_eq("frame_drained", 72'(exq.size()), 72'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) begin
      @(negedge clk);
      check_eq("init_clken", 72'(matrix_frame_clken), 72'd0);
      check_eq("init_window", matrix_window, 72'd0);
      check_eq("init_href", 72'(matrix_frame_href), 72'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) tick();

    run_frame(0, 0, V, -1, -1, H * V);      // reference pattern, continuous strobes
    run_frame(1, 0, V, -1, -1, H * V);      // inverted pattern, no leak from last frame
    run_frame(0, 1, V, -1, -1, H * V);      // one-of-three strobes
    run_frame(2, 2, V, 5, -1, H * V);       // random data/strobes, over-long line 5
    run_frame(0, 0, V, -1, 4, -1);          // reset pulse during row 4
    run_frame(0, 0, V, -1, -1, H * V);      // clean frame after reset
    run_frame(2, 2, V + 2, 2, -1, H * (V + 2));  // lines beyond the frame height

    repeat (5) tick();
    check_eq("final_drained", 72'(exq.size()), 72'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vip_gray_matrix_3x3.md
VIP_GRAY_MATRIX_3X3 -- requirements
Module: vip_gray_matrix_3x3

Interface
REQ-001 Parameter IMG_HDISP, default 640, active pixels per line.
REQ-002 Parameter IMG_VDISP, default 480, active lines per frame.
REQ-003 clk  input  1  pixel clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 per_frame_vsync  input  1  frame valid, high for the whole frame.
REQ-006 per_frame_href  input  1  line valid, high for the whole line.
REQ-007 per_frame_clken  input  1  pixel strobe; a pixel is accepted only when href=1 and clken=1.
REQ-008 per_img_Gray  input  8  gray pixel.
REQ-009 matrix_frame_vsync  output  1  per_frame_vsync delayed 2 clk.
REQ-010 matrix_frame_href  output  1  per_frame_href delayed 2 clk.
REQ-011 matrix_frame_clken  output  1  window-valid strobe.
REQ-012 matrix_window  output  72  3x3 window; [71:64]=p11 ... [7:0]=p33, row-major; p1x oldest row, px1 oldest column.

Function
REQ-013 Each accepted pixel at (row r, col c) SHALL produce exactly one window, with matrix_frame_clken high exactly 2 clk after the accepting edge.
REQ-014 p33=(r,c), p32=(r,c-1), p31=(r,c-2); p2x same columns on row r-1; p1x same columns on row r-2.
REQ-015 Any tap with row<0 or col<0 SHALL read 8'd0, decided from the counters, not from RAM contents.
REQ-016 Two line buffers of depth IMG_HDISP, addressed by column counter: per accepted pixel, read the old word, then write back the new one (line0 <= pixel, line1 <= old line0 word).
REQ-017 Column counter: increments per accepted pixel; clears on href falling edge; at IMG_HDISP further pixels on that line SHALL be dropped (no write, no window).
REQ-018 Row counter: increments on href falling edge if at least one pixel was accepted on that line; saturates at IMG_VDISP-1; clears while vsync=0.
REQ-019 Lines beyond IMG_VDISP SHALL still be processed, using row IMG_VDISP-1 for masking.
REQ-020 Control FSM states WAIT_FRAME, ACTIVE: reset enters WAIT_FRAME; a vsync rising edge moves to ACTIVE; vsync low moves back to WAIT_FRAME; pixels outside ACTIVE are ignored.
REQ-021 vsync falling mid-line: counters clear, no further windows; pipeline windows already in flight SHALL still be emitted.
REQ-022 clken high with href low: no effect on counters, RAM or outputs.
REQ-023 Back-to-back clken on every cycle SHALL be sustained without loss; throughput one window per clk.

Reset
REQ-024 While rst_n=0: all outputs 0, counters 0, FSM WAIT_FRAME, delay pipes 0; RAM contents undefined (masked per REQ-015).
REQ-025 Reset asserted mid-frame SHALL abandon that frame; output resumes only after the next vsync rising edge.

Structure
REQ-026 Shared package vip_pkg: PIX_W=8, window tap index constants, FSM state encoding.
REQ-027 One sub-module vip_line_buffer (single-clock RAM, 1-clk read latency, read-before-write on same address), instantiated twice.
REQ-028 Target size 150-300 lines RTL; no vendor primitives.

Verification
REQ-029 10x8 frame, pixel=r*10+c, continuous clken -> at (r=3,c=4): window = 12,13,14 / 22,23,24 / 32,33,34; 80 windows per frame.
REQ-030 Same frame, check (0,0) -> window all zero except p33=0; (1,1) -> 0,0,0 / 0,0,1 / 0,10,11.
REQ-031 clken toggled 1-of-3 cycles -> identical window sequence as REQ-029; each window clken exactly 2 clk after the input.
REQ-032 Line with 12 strobes (IMG_HDISP=10) -> 10 windows; pixels 11-12 dropped; next line column restarts at 0.
REQ-033 rst_n pulsed low at row 4 -> outputs 0 immediately; no windows until the next vsync rise; next frame windows equal REQ-029.
REQ-034 Second frame with pixel=255-(r*10+c) -> row 0/1 taps zero; no data leaks from the previous frame.
